// File: rtl/tlb_pkg.sv
// Shared constants, TLB entry layout and flush FSM encoding for the TLB array.
// TLB_ASID_EN adds the ASID field to the entry layout.
package tlb_pkg;

    localparam int unsigned TLB_NUM_SETS = 16;
    localparam int unsigned TLB_NUM_WAYS = 4;
    localparam int unsigned TLB_VPN_W    = 20;
    localparam int unsigned TLB_PPN_W    = 20;
    localparam int unsigned TLB_PERM_W   = 2;
    localparam int unsigned TLB_ASID_W   = 8;
    localparam int unsigned TLB_AGE_W    = $clog2(TLB_NUM_WAYS);

    // Field widths follow the package constants; the array parameters must match them.
    typedef struct packed {
        logic                  valid;
        logic [TLB_VPN_W-1:0]  vpn;
        logic [TLB_PPN_W-1:0]  ppn;
        logic [TLB_PERM_W-1:0] perms;
`ifdef TLB_ASID_EN
        logic [TLB_ASID_W-1:0] asid;
`endif
        logic [TLB_AGE_W-1:0]  age;
    } tlb_entry_t;

    typedef enum logic [1:0] {
        FL_IDLE,
        FL_WALK,
        FL_DONE
    } flush_state_t;

endpackage

// File: rtl/tlb_lru_sel.sv
// Combinational way selection and age update for one TLB set:
// picks the hit/target way and computes the set's ages after accessing it.
module tlb_lru_sel #(
    parameter  int unsigned NUM_WAYS = 4,
    localparam int unsigned WAY_W    = $clog2(NUM_WAYS)
) (
    input  logic [NUM_WAYS-1:0]            i_valid,
    input  logic [NUM_WAYS-1:0]            i_match,
    input  logic [NUM_WAYS-1:0][WAY_W-1:0] i_age,
    output logic                           o_hit,
    output logic [WAY_W-1:0]               o_way,
    output logic [NUM_WAYS-1:0][WAY_W-1:0] o_age
);

    logic             w_hit;
    logic [WAY_W-1:0] w_hit_way;
    logic             w_has_inv;
    logic [WAY_W-1:0] w_inv_way;
    logic [WAY_W-1:0] w_old_way;
    logic [WAY_W-1:0] w_old_age;
    logic [WAY_W-1:0] w_tgt;
    logic [WAY_W-1:0] w_acc_age;

    always_comb begin
        w_hit     = 1'b0;
        w_hit_way = '0;
        w_has_inv = 1'b0;
        w_inv_way = '0;
        w_old_way = '0;
        w_old_age = i_age[0];
        for (int unsigned w = 0; w < NUM_WAYS; w++) begin
            if (i_match[w] && !w_hit) begin
                w_hit     = 1'b1;
                w_hit_way = WAY_W'(w);
            end
            if (!i_valid[w] && !w_has_inv) begin
                w_has_inv = 1'b1;
                w_inv_way = WAY_W'(w);
            end
            if (i_age[w] > w_old_age) begin
                w_old_age = i_age[w];
                w_old_way = WAY_W'(w);
            end
        end

        if (w_hit)
            w_tgt = w_hit_way;
        else if (w_has_inv)
            w_tgt = w_inv_way;
        else
            w_tgt = w_old_way;

        // An empty way counts as the oldest, so filling it ages every valid way.
        w_acc_age = i_valid[w_tgt] ? i_age[w_tgt] : '1;

        for (int unsigned w = 0; w < NUM_WAYS; w++) begin
            if (WAY_W'(w) == w_tgt)
                o_age[w] = '0;
            else if (i_valid[w] && (i_age[w] < w_acc_age))
                o_age[w] = i_age[w] + 1'b1;
            else
                o_age[w] = i_age[w];
        end
    end

    assign o_hit = w_hit;
    assign o_way = w_tgt;

endmodule

// File: rtl/tlb_assoc_array.sv
// Set-associative TLB array: lookup with 1-cycle response, LRU fill, set-walking flush.
// Define TLB_ASID_EN for ASID storage, ASID-qualified matching and selective flush.
module tlb_assoc_array
    import tlb_pkg::*;
#(
    parameter int unsigned NUM_SETS = TLB_NUM_SETS,
    parameter int unsigned NUM_WAYS = TLB_NUM_WAYS,
    parameter int unsigned VPN_W    = TLB_VPN_W,
    parameter int unsigned PPN_W    = TLB_PPN_W,
    parameter int unsigned PERM_W   = TLB_PERM_W,
    parameter int unsigned ASID_W   = TLB_ASID_W
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        lk_valid,
    output logic                        lk_ready,
    input  logic [VPN_W-1:0]            lk_vpn,
    input  logic [ASID_W-1:0]           lk_asid,
    output logic                        rsp_valid,
    output logic                        rsp_hit,
    output logic [PPN_W-1:0]            rsp_ppn,
    output logic [PERM_W-1:0]           rsp_perms,
    output logic [$clog2(NUM_WAYS)-1:0] rsp_way,
    input  logic                        fill_valid,
    output logic                        fill_ready,
    input  logic [VPN_W-1:0]            fill_vpn,
    input  logic [PPN_W-1:0]            fill_ppn,
    input  logic [PERM_W-1:0]           fill_perms,
    input  logic [ASID_W-1:0]           fill_asid,
    input  logic                        flush_req,
    input  logic                        flush_all,
    input  logic [ASID_W-1:0]           flush_asid,
    output logic                        flush_busy,
    output logic                        flush_done
);

    localparam int unsigned SET_W = $clog2(NUM_SETS);
    localparam int unsigned WAY_W = $clog2(NUM_WAYS);

    tlb_entry_t   r_mem [NUM_SETS][NUM_WAYS];
    flush_state_t r_state;
    flush_state_t w_state_nxt;
    logic [SET_W-1:0] r_walk_set;

    logic              r_rsp_valid;
    logic              r_rsp_hit;
    logic [PPN_W-1:0]  r_rsp_ppn;
    logic [PERM_W-1:0] r_rsp_perms;
    logic [WAY_W-1:0]  r_rsp_way;

    logic                           w_lk_fire;
    logic                           w_fill_fire;
    logic [VPN_W-1:0]               w_vpn;
    logic [SET_W-1:0]               w_set;
    logic [NUM_WAYS-1:0]            w_valid;
    logic [NUM_WAYS-1:0]            w_match;
    logic [NUM_WAYS-1:0][WAY_W-1:0] w_age;
    logic [NUM_WAYS-1:0][WAY_W-1:0] w_age_nxt;
    logic                           w_hit;
    logic [WAY_W-1:0]               w_way;

`ifdef TLB_ASID_EN
    logic              r_fl_all;
    logic [ASID_W-1:0] r_fl_asid;
    logic [ASID_W-1:0] w_asid;
    assign w_asid = fill_valid ? fill_asid : lk_asid;
`else
    logic w_unused;
    assign w_unused = ^{lk_asid, fill_asid, flush_asid, flush_all};
`endif

    assign lk_ready    = !flush_busy && !fill_valid;
    assign fill_ready  = !flush_busy;
    assign w_lk_fire   = lk_valid && lk_ready;
    assign w_fill_fire = fill_valid && fill_ready;

    // Fill owns the set port whenever it is presented, since it blocks lookup.
    assign w_vpn = fill_valid ? fill_vpn : lk_vpn;
    assign w_set = w_vpn[SET_W-1:0];

    always_comb begin
        w_valid = '0;
        w_match = '0;
        w_age   = '0;
        for (int unsigned w = 0; w < NUM_WAYS; w++) begin
            w_valid[w] = r_mem[w_set][w].valid;
            w_age[w]   = r_mem[w_set][w].age;
            w_match[w] = r_mem[w_set][w].valid && (r_mem[w_set][w].vpn == w_vpn);
`ifdef TLB_ASID_EN
            if (r_mem[w_set][w].asid != w_asid)
                w_match[w] = 1'b0;
`endif
        end
    end

    tlb_lru_sel #(
        .NUM_WAYS (NUM_WAYS)
    ) u_lru_sel (
        .i_valid (w_valid),
        .i_match (w_match),
        .i_age   (w_age),
        .o_hit   (w_hit),
        .o_way   (w_way),
        .o_age   (w_age_nxt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rsp_valid <= 1'b0;
            r_rsp_hit   <= 1'b0;
            r_rsp_ppn   <= '0;
            r_rsp_perms <= '0;
            r_rsp_way   <= '0;
        end else begin
            r_rsp_valid <= w_lk_fire;
            r_rsp_hit   <= w_lk_fire && w_hit;
            if (w_lk_fire && w_hit) begin
                r_rsp_ppn   <= r_mem[w_set][w_way].ppn;
                r_rsp_perms <= r_mem[w_set][w_way].perms;
                r_rsp_way   <= w_way;
            end else begin
                r_rsp_ppn   <= '0;
                r_rsp_perms <= '0;
                r_rsp_way   <= '0;
            end
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_hit   = r_rsp_hit;
    assign rsp_ppn   = r_rsp_ppn;
    assign rsp_perms = r_rsp_perms;
    assign rsp_way   = r_rsp_way;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned s = 0; s < NUM_SETS; s++)
                for (int unsigned w = 0; w < NUM_WAYS; w++)
                    r_mem[s][w] <= '0;
        end else begin
            if ((w_lk_fire && w_hit) || w_fill_fire)
                for (int unsigned w = 0; w < NUM_WAYS; w++)
                    r_mem[w_set][w].age <= w_age_nxt[w];
            if (w_fill_fire) begin
                r_mem[w_set][w_way].valid <= 1'b1;
                r_mem[w_set][w_way].vpn   <= fill_vpn;
                r_mem[w_set][w_way].ppn   <= fill_ppn;
                r_mem[w_set][w_way].perms <= fill_perms;
`ifdef TLB_ASID_EN
                r_mem[w_set][w_way].asid  <= fill_asid;
`endif
            end
            if (r_state == FL_WALK) begin
                for (int unsigned w = 0; w < NUM_WAYS; w++) begin
`ifdef TLB_ASID_EN
                    if (r_fl_all || (r_mem[r_walk_set][w].asid == r_fl_asid))
                        r_mem[r_walk_set][w].valid <= 1'b0;
`else
                    r_mem[r_walk_set][w].valid <= 1'b0;
`endif
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= FL_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            FL_IDLE: if (flush_req) w_state_nxt = FL_WALK;
            FL_WALK: if (r_walk_set == SET_W'(NUM_SETS - 1)) w_state_nxt = FL_DONE;
            FL_DONE: w_state_nxt = FL_IDLE;
            default: w_state_nxt = FL_IDLE;
        endcase
    end

    always_comb begin
        flush_busy = (r_state == FL_WALK) || (r_state == FL_DONE);
        flush_done = (r_state == FL_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_walk_set <= '0;
`ifdef TLB_ASID_EN
            r_fl_all   <= 1'b0;
            r_fl_asid  <= '0;
`endif
        end else if (r_state == FL_IDLE) begin
            r_walk_set <= '0;
`ifdef TLB_ASID_EN
            if (flush_req) begin
                r_fl_all  <= flush_all;
                r_fl_asid <= flush_asid;
            end
`endif
        end else if (r_state == FL_WALK) begin
            r_walk_set <= r_walk_set + 1'b1;
        end
    end

endmodule

// File: doc/tlb_assoc_array.md
TLB_ASSOC_ARRAY -- requirements
Module: tlb_assoc_array

Interface
REQ-001 SHALL have parameter NUM_SETS, default 16: number of sets, a power of two, at least 2.
REQ-002 SHALL have parameter NUM_WAYS, default 4: ways per set, a power of two, at least 2.
REQ-003 SHALL have parameter VPN_W, default 20: virtual page number width.
REQ-004 SHALL have parameter PPN_W, default 20: physical page number width.
REQ-005 SHALL have parameter PERM_W, default 2: permission field width.
REQ-006 SHALL have parameter ASID_W, default 8: address-space ID width.
REQ-007 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-008 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-009 SHALL have ports lk_valid (in, 1), lk_ready (out, 1), lk_vpn (in, VPN_W) and lk_asid (in, ASID_W): the lookup request.
REQ-010 SHALL have ports rsp_valid (out, 1), rsp_hit (out, 1), rsp_ppn (out, PPN_W), rsp_perms (out, PERM_W) and rsp_way (out, clog2(NUM_WAYS)): the lookup response.
REQ-011 SHALL have ports fill_valid (in, 1), fill_ready (out, 1), fill_vpn (in, VPN_W), fill_ppn (in, PPN_W), fill_perms (in, PERM_W) and fill_asid (in, ASID_W): the fill request.
REQ-012 SHALL have ports flush_req (in, 1), flush_all (in, 1), flush_asid (in, ASID_W), flush_busy (out, 1) and flush_done (out, 1): the flush interface.

Function
REQ-013 Set index SHALL be vpn[clog2(NUM_SETS)-1:0].
REQ-014 Each entry SHALL store valid, the full VPN, PPN, perms, ASID, and an age of clog2(NUM_WAYS) bits.
REQ-015 lk_ready SHALL equal !flush_busy && !fill_valid; fill_ready SHALL equal !flush_busy.
- Fill therefore has priority over lookup, so the two never complete in the same cycle.
REQ-016 An accepted lookup SHALL produce a response with latency 1.
- rsp_valid is a one-cycle pulse with no backpressure.
- The response reflects array state before the acceptance edge.
REQ-017 A hit SHALL require valid, a VPN match and an ASID match; on a miss, rsp_ppn, rsp_perms and rsp_way SHALL be 0.
REQ-018 A hit SHALL update that set's ages at the acceptance edge, and at most one way SHALL hit.
- Age update on access to way w with old age a: w is set to 0.
- Every other valid way with age < a increments.
- All other ways are unchanged.
REQ-019 An accepted fill SHALL choose its target way in this order:
- the way holding a matching VPN and ASID (overwrite, so no duplicates);
- else the lowest-index invalid way;
- else the valid way with the largest age, lowest index on a tie.
REQ-020 The filled way SHALL become valid, with its age updated as in REQ-018.
REQ-021 The flush FSM SHALL have states IDLE, WALK and DONE.
- IDLE→WALK when flush_req=1, which also latches flush_all and flush_asid.
- WALK visits sets 0..NUM_SETS-1, one per cycle, and takes exactly NUM_SETS cycles.
- WALK→DONE after the last set.
- DONE→IDLE unconditionally.
REQ-022 flush_busy SHALL be 1 in WALK and DONE; flush_done SHALL be 1 only in DONE.
- flush_req outside IDLE SHALL be ignored.
REQ-023 In WALK, each way in the current set SHALL be invalidated when flush_all=1 or its stored ASID equals the latched flush_asid.
REQ-024 A lookup accepted on the same edge that flush_req is sampled SHALL still receive its response.
- Its hit age update SHALL occur.

Reset
REQ-025 On reset, all entries SHALL become invalid with age 0, the FSM SHALL go to IDLE, and rsp_valid, rsp_hit, rsp_ppn, rsp_perms, rsp_way and flush_done SHALL be 0.
REQ-026 Reset during WALK SHALL abort the flush with no flush_done pulse, and a pending response SHALL be dropped.

Configuration
REQ-027 With TLB_ASID_EN defined, ASID storage, ASID matching in lookup and fill, and selective flush SHALL be present.
REQ-028 Without TLB_ASID_EN, ASID inputs SHALL be ignored, ASID storage SHALL be removed, matching SHALL use VPN only, and every flush SHALL invalidate everything.

Structure
REQ-029 A shared package tlb_pkg SHALL hold:
- the default parameter constants;
- the entry struct type;
- the flush FSM state enum.
REQ-030 Victim selection and age update SHALL live in sub-module tlb_lru_sel.
- It is combinational over one set's valid and age vectors.
- It is instantiated once for the lookup/fill path.

Verification
REQ-031 Reset, then look up VPN 0x00005 → rsp_valid exactly one cycle later, with rsp_hit=0 and rsp_ppn=0.
REQ-032 Fill VPN 0xABCD5, PPN 0x12345, perms 2'b11, ASID 3, then look up the same VPN with ASID 3 → hit, PPN 0x12345, way 0; the same lookup with ASID 4 under TLB_ASID_EN → miss.
REQ-033 Fill 4 distinct VPNs into set 7, look up the first, then fill a fifth → the fifth replaces the second-filled way, and a lookup of the second VPN misses.
REQ-034 Refill an existing VPN/ASID with PPN 0xBBBBB → same way is overwritten, and no other way in the set changes.
REQ-035 Fill ASID 1 and ASID 2 entries, then flush_req with flush_all=0 and flush_asid=1 → flush_busy is high for 17 cycles, then the ASID 1 entries miss and the ASID 2 entries hit.
REQ-036 Assert rst in the 5th WALK cycle → flush_done never pulses, all entries are invalid, and lk_ready=1 after reset.
